pipe_stage_reg: RTL and testbench
=================================

PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 SHALL have parameter DATA_W, default 32, the width of the datapath payload (pc, register data, immediate, indices packed by the instantiating stage).
REQ-002 SHALL have parameter CTRL_W, default 16, the width of the control payload (ALU selects, opcode, func fields, dm_w_en, halt, wb_sel, wb_en).
REQ-003 SHALL have parameter NOP_CTRL, default all-zero CTRL_W value, the control word that encodes a bubble (no write-back, no memory write, no halt).
REQ-004 SHALL have parameter CNT_W, default 16, the width of the bubble counter.
REQ-005 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-006 SHALL have port rst, input, 1, reset: asynchronous, active-high.
REQ-007 SHALL have port flush, input, 1, synchronous discard of all held entries (branch/jump redirect).
REQ-008 SHALL have port in_valid, input, 1, upstream entry present.
REQ-009 SHALL have port in_ready, output, 1, the block can accept an entry this cycle.
REQ-010 SHALL have port in_data, input, DATA_W, upstream payload.
REQ-011 SHALL have port in_ctrl, input, CTRL_W, upstream control word.
REQ-012 SHALL have port out_valid, output, 1, downstream entry present.
REQ-013 SHALL have port out_ready, input, 1, downstream accepts this cycle.
REQ-014 SHALL have port out_data, output, DATA_W, downstream payload.
REQ-015 SHALL have port out_ctrl, output, CTRL_W, downstream control word.
REQ-016 SHALL have port occupancy, output, 2, number of held entries (0..2).
REQ-017 SHALL have port bubble_cnt, output, CNT_W, count of cycles in which downstream was ready but no entry was presented.

Function
REQ-018 SHALL hold two entries: a main register driving the outputs and a skid register; the states are EMPTY (0), ONE (main only) and FULL (main and skid).
REQ-019 SHALL define accept = in_valid & in_ready and pop = out_valid & out_ready.
REQ-020 SHALL drive in_ready = 1 in EMPTY and ONE and 0 in FULL, from registered state only, with no combinational path from out_ready.
REQ-021 SHALL drive out_valid = 1 in ONE and FULL.
REQ-022 SHALL drive out_data = 0 and out_ctrl = NOP_CTRL whenever out_valid = 0.
REQ-023 SHALL transition from EMPTY on accept to ONE, loading main from the inputs.
REQ-024 SHALL transition from ONE as follows:
- accept without pop: to FULL, loading skid.
- pop without accept: to EMPTY.
- accept with pop: remain in ONE, loading main from the inputs.
- neither: hold.
REQ-025 SHALL transition from FULL on pop to ONE, moving skid into main; without pop, FULL holds.
REQ-026 SHALL present an accepted entry on the outputs one cycle after acceptance when the block was EMPTY (latency 1), and SHALL deliver entries in acceptance order with no loss or duplication.
REQ-027 SHALL, when flush = 1, go to EMPTY on the next edge, discard main, skid and any same-cycle accept, and take priority over accept and pop; pop in the flush cycle still counts as delivered downstream.
REQ-028 SHALL keep out_data and out_ctrl stable while out_valid = 1 and out_ready = 0.
REQ-029 SHALL increment bubble_cnt on every cycle where out_valid = 0 and out_ready = 1, saturating at 2^CNT_W - 1; flush SHALL NOT clear it.
REQ-030 SHALL drive occupancy as 0, 1 or 2 to match EMPTY, ONE or FULL.

Reset
REQ-031 SHALL, on rst = 1 and independent of clk, immediately force:
- state EMPTY, occupancy = 0.
- out_valid = 0, out_data = 0, out_ctrl = NOP_CTRL.
- in_ready = 1, bubble_cnt = 0.
- main and skid = 0.
REQ-032 SHALL resume normal operation on the first rising edge after rst deasserts; rst asserted mid-transfer SHALL discard all entries.

Verification
REQ-033 SHALL cover streaming: out_ready = 1, entries 0x10..0x14 offered on consecutive cycles -> each appears one cycle later in order, occupancy stays 1, in_ready stays 1.
REQ-034 SHALL cover backpressure: out_ready = 0, entries A = 0xA, B = 0xB accepted -> occupancy = 2, in_ready = 0, out_data holds 0xA; out_ready = 1 -> 0xA then 0xB, in_ready returns to 1 after the first pop.
REQ-035 SHALL cover flush in FULL with in_valid = 1: next cycle out_valid = 0, out_ctrl = NOP_CTRL, occupancy = 0, and the offered entry is never output.
REQ-036 SHALL cover bubble counting: 5 idle cycles with out_ready = 1 -> bubble_cnt = 5; with CNT_W = 2 and 6 idle cycles -> bubble_cnt = 3.
REQ-037 SHALL cover asynchronous reset mid-cycle in FULL: outputs go to reset values before the next clk edge, and the first accept after release reaches out_data one cycle later.

Source files
------------

// File: rtl/pipe_stage_reg.sv
// Two-entry pipeline stage register (main + skid) with a registered-only in_ready,
// synchronous flush and a saturating count of downstream bubble cycles.
module pipe_stage_reg #(
  parameter int unsigned             DATA_W   = 32,
  parameter int unsigned             CTRL_W   = 16,
  parameter logic [CTRL_W-1:0]       NOP_CTRL = '0,
  parameter int unsigned             CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  bubble_cnt
);

  // Encoding doubles as the entry count driven on occupancy.
  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_FULL  = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   main_data_q, main_data_d;
  logic [CTRL_W-1:0]   main_ctrl_q, main_ctrl_d;
  logic [DATA_W-1:0]   skid_data_q, skid_data_d;
  logic [CTRL_W-1:0]   skid_ctrl_q, skid_ctrl_d;
  logic [CNT_W-1:0]    bubble_q, bubble_d;

  logic accept;
  logic pop;

  assign accept = in_valid & in_ready;
  assign pop    = out_valid & out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_data_q <= '0;
      main_ctrl_q <= '0;
      skid_data_q <= '0;
      skid_ctrl_q <= '0;
      bubble_q    <= '0;
    end else begin
      main_data_q <= main_data_d;
      main_ctrl_q <= main_ctrl_d;
      skid_data_q <= skid_data_d;
      skid_ctrl_q <= skid_ctrl_d;
      bubble_q    <= bubble_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    main_data_d = main_data_q;
    main_ctrl_d = main_ctrl_q;
    skid_data_d = skid_data_q;
    skid_ctrl_d = skid_ctrl_q;

    unique case (state_q)
      S_EMPTY: begin
        if (accept) begin
          state_d     = S_ONE;
          main_data_d = in_data;
          main_ctrl_d = in_ctrl;
        end
      end
      S_ONE: begin
        if (accept && !pop) begin
          state_d     = S_FULL;
          skid_data_d = in_data;
          skid_ctrl_d = in_ctrl;
        end else if (!accept && pop) begin
          state_d = S_EMPTY;
        end else if (accept && pop) begin
          main_data_d = in_data;
          main_ctrl_d = in_ctrl;
        end
      end
      S_FULL: begin
        if (pop) begin
          state_d     = S_ONE;
          main_data_d = skid_data_q;
          main_ctrl_d = skid_ctrl_q;
        end
      end
      default: state_d = S_EMPTY;
    endcase

    // Flush only drops the entries; stale payload stays masked off the outputs.
    if (flush) begin
      state_d = S_EMPTY;
    end
  end

  always_comb begin
    bubble_d = bubble_q;
    if (!out_valid && out_ready && (bubble_q != CNT_MAX)) begin
      bubble_d = bubble_q + 1'b1;
    end
  end

  always_comb begin
    out_valid  = (state_q == S_ONE) || (state_q == S_FULL);
    in_ready   = (state_q != S_FULL);
    occupancy  = state_q;
    out_data   = out_valid ? main_data_q : '0;
    out_ctrl   = out_valid ? main_ctrl_q : NOP_CTRL;
    bubble_cnt = bubble_q;
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: a queue-based reference checked every cycle
// plus literal expectations for streaming, backpressure, flush, bubbles and reset.
module tb_pipe_stage_reg;

  localparam logic [15:0] NOP = 16'hA5A5;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic [31:0] in_data;
  logic [15:0] in_ctrl;
  logic        out_ready;

  logic        in_ready;
  logic        out_valid;
  logic [31:0] out_data;
  logic [15:0] out_ctrl;
  logic [1:0]  occupancy;
  logic [15:0] bubble_cnt;

  logic        s_in_ready;
  logic        s_out_valid;
  logic [7:0]  s_out_data;
  logic [3:0]  s_out_ctrl;
  logic [1:0]  s_occupancy;
  logic [1:0]  s_bubble_cnt;

  pipe_stage_reg #(.DATA_W(32), .CTRL_W(16), .NOP_CTRL(NOP), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_ctrl(in_ctrl),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_ctrl(out_ctrl),
    .occupancy(occupancy), .bubble_cnt(bubble_cnt)
  );

  pipe_stage_reg #(.DATA_W(8), .CTRL_W(4), .NOP_CTRL(4'h0), .CNT_W(2)) dut_small (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(s_in_ready), .in_data(in_data[7:0]), .in_ctrl(in_ctrl[3:0]),
    .out_valid(s_out_valid), .out_ready(out_ready), .out_data(s_out_data), .out_ctrl(s_out_ctrl),
    .occupancy(s_occupancy), .bubble_cnt(s_bubble_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [31:0] d;
    logic [15:0] c;
  } ent_t;

  ent_t mq[$];
  int   bub_big;
  int   bub_small;
  int   n_tests;
  int   n_fail;
  bit   saw_flushed;

  function automatic logic [15:0] ctrl_of(input logic [31:0] d);
    return d[15:0] ^ 16'h1234;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison against the reference queue.
  always @(negedge clk) begin
    ent_t  head;
    int    sz;
    sz = mq.size();
    if (sz > 0) head = mq[0];
    else begin
      head.d = '0;
      head.c = NOP;
    end
    chk("cyc_out_valid", {31'd0, out_valid}, {31'd0, sz > 0});
    chk("cyc_out_data",  out_data, head.d);
    chk("cyc_out_ctrl",  {16'd0, out_ctrl}, {16'd0, head.c});
    chk("cyc_occupancy", {30'd0, occupancy}, sz);
    chk("cyc_in_ready",  {31'd0, in_ready}, {31'd0, sz < 2});
    chk("cyc_bubble",    {16'd0, bubble_cnt}, bub_big);
    chk("cyc_s_occ",     {30'd0, s_occupancy}, sz);
    chk("cyc_s_bubble",  {30'd0, s_bubble_cnt}, bub_small);
    if (out_valid && out_data == 32'h99) saw_flushed = 1'b1;
  end

  task automatic step(input logic iv, input logic [31:0] d, input logic ordy, input logic fl);
    bit   pop;
    bit   acc;
    ent_t e;
    in_valid  = iv;
    in_data   = d;
    in_ctrl   = ctrl_of(d);
    out_ready = ordy;
    flush     = fl;
    @(posedge clk);
    pop = (mq.size() > 0) && ordy;
    acc = iv && (mq.size() < 2);
    if (mq.size() == 0 && ordy) begin
      if (bub_big < 65535) bub_big++;
      if (bub_small < 3) bub_small++;
    end
    if (fl) begin
      mq.delete();
    end else begin
      if (pop) void'(mq.pop_front());
      if (acc) begin
        e.d = d;
        e.c = ctrl_of(d);
        mq.push_back(e);
      end
    end
    #2;
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_occ"},    {30'd0, occupancy}, 0);
    chk({tag, "_oval"},   {31'd0, out_valid}, 0);
    chk({tag, "_odata"},  out_data, 0);
    chk({tag, "_octrl"},  {16'd0, out_ctrl}, {16'd0, NOP});
    chk({tag, "_iready"}, {31'd0, in_ready}, 1);
    chk({tag, "_bubble"}, {16'd0, bubble_cnt}, 0);
  endtask

  initial begin
    n_tests = 0; n_fail = 0; bub_big = 0; bub_small = 0; saw_flushed = 1'b0;
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0; in_ctrl = '0; out_ready = 1'b0;
    #1 rst = 1'b1;
    @(posedge clk); @(posedge clk); #2;
    reset_checks("rst");
    rst = 1'b0;

    // Bubble counting: 5 then 6 idle ready cycles.
    for (int i = 0; i < 5; i++) step(1'b0, 32'h0, 1'b1, 1'b0);
    chk("bubble5", {16'd0, bubble_cnt}, 5);
    step(1'b0, 32'h0, 1'b1, 1'b0);
    chk("bubble6", {16'd0, bubble_cnt}, 6);
    chk("bubble_sat", {30'd0, s_bubble_cnt}, 3);

    // Streaming 0x10..0x14.
    for (int k = 0; k < 5; k++) begin
      step(1'b1, 32'h10 + k, 1'b1, 1'b0);
      chk("stream_data", out_data, 32'h10 + k);
      chk("stream_occ",  {30'd0, occupancy}, 1);
      chk("stream_rdy",  {31'd0, in_ready}, 1);
    end
    step(1'b0, 32'h0, 1'b1, 1'b0);
    chk("stream_drain", {31'd0, out_valid}, 0);

    // Backpressure A, B.
    step(1'b1, 32'hA, 1'b0, 1'b0);
    step(1'b1, 32'hB, 1'b0, 1'b0);
    chk("bp_occ",  {30'd0, occupancy}, 2);
    chk("bp_rdy",  {31'd0, in_ready}, 0);
    chk("bp_hold", out_data, 32'hA);
    step(1'b1, 32'hC, 1'b0, 1'b0);
    chk("bp_stable", out_data, 32'hA);
    step(1'b0, 32'h0, 1'b1, 1'b0);
    chk("bp_second", out_data, 32'hB);
    chk("bp_rdy_back", {31'd0, in_ready}, 1);
    step(1'b0, 32'h0, 1'b1, 1'b0);
    chk("bp_empty", {30'd0, occupancy}, 0);

    // Flush while FULL with an entry offered.
    step(1'b1, 32'h20, 1'b0, 1'b0);
    step(1'b1, 32'h21, 1'b0, 1'b0);
    step(1'b1, 32'h99, 1'b1, 1'b1);
    chk("flush_oval", {31'd0, out_valid}, 0);
    chk("flush_ctrl", {16'd0, out_ctrl}, {16'd0, NOP});
    chk("flush_occ",  {30'd0, occupancy}, 0);
    for (int i = 0; i < 3; i++) step(1'b0, 32'h0, 1'b1, 1'b0);
    chk("flush_never_out", {31'd0, saw_flushed}, 0);

    // Flush in ONE with accept and pop together.
    step(1'b1, 32'h40, 1'b0, 1'b0);
    step(1'b1, 32'h41, 1'b1, 1'b1);
    chk("flush_one_occ", {30'd0, occupancy}, 0);

    // Asynchronous reset mid-cycle while FULL.
    step(1'b1, 32'h30, 1'b0, 1'b0);
    step(1'b1, 32'h31, 1'b0, 1'b0);
    chk("pre_rst_occ", {30'd0, occupancy}, 2);
    rst = 1'b1;
    mq.delete(); bub_big = 0; bub_small = 0;
    #1;
    reset_checks("async_rst");
    @(posedge clk); #2;
    rst = 1'b0;
    step(1'b1, 32'h55, 1'b0, 1'b0);
    chk("post_rst_data", out_data, 32'h55);
    chk("post_rst_occ",  {30'd0, occupancy}, 1);

    // Mixed traffic tail, checked by the per-cycle reference.
    for (int i = 0; i < 60; i++) begin
      step(1'($urandom_range(1)), 32'h100 + i, 1'($urandom_range(1)), 1'($urandom_range(15) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
